// File: rtl/wrr_pkt_arbiter_if.sv
// Bundle of the arbiter's rx streams, weights and merged output stream.
// master = traffic source / sink side, slave = the arbiter itself.
interface wrr_pkt_arbiter_if #(
  parameter int DATA_WIDTH   = 64,
  parameter int CTRL_WIDTH   = DATA_WIDTH/8,
  parameter int NUM_QUEUES   = 8,
  parameter int WEIGHT_WIDTH = 4
);
  localparam int QW = $clog2(NUM_QUEUES);

  logic [NUM_QUEUES*DATA_WIDTH-1:0]   in_data;
  logic [NUM_QUEUES*CTRL_WIDTH-1:0]   in_ctrl;
  logic [NUM_QUEUES-1:0]              in_wr;
  logic [NUM_QUEUES-1:0]              in_rdy;
  logic [NUM_QUEUES*WEIGHT_WIDTH-1:0] weights;
  logic [DATA_WIDTH-1:0]              out_data;
  logic [CTRL_WIDTH-1:0]              out_ctrl;
  logic                               out_wr;
  logic                               out_rdy;
  logic [QW-1:0]                      cur_queue;
  logic                               eop;
  logic                               round_start;

  modport master (
    output in_data, in_ctrl, in_wr, weights, out_rdy,
    input  in_rdy, out_data, out_ctrl, out_wr, cur_queue, eop, round_start
  );

  modport slave (
    input  in_data, in_ctrl, in_wr, weights, out_rdy,
    output in_rdy, out_data, out_ctrl, out_wr, cur_queue, eop, round_start
  );
endinterface

// File: rtl/wrr_pkt_arbiter.sv
// Packet-granular weighted round-robin merge of NUM_QUEUES rx streams into one.
// Each queue gets up to weight[q] whole packets per credit round; weight 0 disables it.

module wrr_pkt_fifo #(
  parameter int WIDTH      = 72,
  parameter int DEPTH_BITS = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_rd,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_empty,
  output logic             o_nearly_full,
  output logic             o_more
);
  localparam int DEPTH = 1 << DEPTH_BITS;
  localparam int CW    = DEPTH_BITS + 1;
  localparam int NF_I  = DEPTH - 1;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] NF_C   = CW'(NF_I);

  logic [WIDTH-1:0]      r_mem [DEPTH];
  logic [DEPTH_BITS-1:0] r_wp, r_rp;
  logic [CW-1:0]         r_cnt;
  logic                  w_wr, w_rd;

  assign w_wr = i_wr && (r_cnt != FULL_C);
  assign w_rd = i_rd && (r_cnt != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_wr) r_wp <= r_wp + DEPTH_BITS'(1);
      if (w_rd) r_rp <= r_rp + DEPTH_BITS'(1);
      case ({w_wr, w_rd})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wp] <= i_din;
  end

  assign o_dout        = r_mem[r_rp];
  assign o_empty       = (r_cnt == '0);
  assign o_nearly_full = (r_cnt >= NF_C);
  // Occupancy after a pop this cycle, counting a write landing in the same cycle.
  assign o_more        = (r_cnt > CW'(1)) || w_wr;
endmodule

module wrr_pkt_arbiter #(
  parameter int DATA_WIDTH      = 64,
  parameter int CTRL_WIDTH      = DATA_WIDTH/8,
  parameter int NUM_QUEUES      = 8,
  parameter int WEIGHT_WIDTH    = 4,
  parameter int FIFO_DEPTH_BITS = 2
) (
  input  logic              clk,
  input  logic              reset,
  wrr_pkt_arbiter_if.slave  bus
);
  localparam int QW = $clog2(NUM_QUEUES);
  localparam int EW = DATA_WIDTH + CTRL_WIDTH;
  localparam logic [0:0] ST_SELECT = 1'b0;
  localparam logic [0:0] ST_XFER   = 1'b1;

  logic [NUM_QUEUES-1:0][DATA_WIDTH-1:0]   w_in_data;
  logic [NUM_QUEUES-1:0][CTRL_WIDTH-1:0]   w_in_ctrl;
  logic [NUM_QUEUES-1:0][WEIGHT_WIDTH-1:0] w_wt;
  logic [NUM_QUEUES-1:0][EW-1:0]           w_dout;
  logic [NUM_QUEUES-1:0]                   w_empty, w_nf, w_more, w_pop;
  logic [NUM_QUEUES-1:0]                   w_elig, w_backlog;

  logic [0:0]                              r_state;
  logic [QW-1:0]                           r_ptr, r_cur;
  logic [NUM_QUEUES-1:0][WEIGHT_WIDTH-1:0] r_credit;
  logic                                    r_prev_zero;
  logic [DATA_WIDTH-1:0]                   r_out_data;
  logic [CTRL_WIDTH-1:0]                   r_out_ctrl;
  logic                                    r_out_wr, r_eop, r_rs;

  logic [QW-1:0]         w_sel, w_ptr_nxt;
  logic                  w_found, w_do_pop, w_last;
  logic [EW-1:0]         w_head;
  logic [CTRL_WIDTH-1:0] w_head_ctrl;

  assign w_in_data = bus.in_data;
  assign w_in_ctrl = bus.in_ctrl;
  assign w_wt      = bus.weights;

  generate
    for (genvar q = 0; q < NUM_QUEUES; q++) begin : g_q
      wrr_pkt_fifo #(.WIDTH(EW), .DEPTH_BITS(FIFO_DEPTH_BITS)) u_fifo (
        .clk           (clk),
        .rst           (reset),
        .i_wr          (bus.in_wr[q]),
        .i_din         ({w_in_ctrl[q], w_in_data[q]}),
        .i_rd          (w_pop[q]),
        .o_dout        (w_dout[q]),
        .o_empty       (w_empty[q]),
        .o_nearly_full (w_nf[q]),
        .o_more        (w_more[q])
      );
      assign w_pop[q]     = w_do_pop && (r_cur == QW'(q));
      assign w_elig[q]    = !w_empty[q] && (r_credit[q] != '0) && (w_wt[q] != '0);
      assign w_backlog[q] = !w_empty[q] && (w_wt[q] != '0);
    end
  endgenerate

  assign bus.in_rdy = ~w_nf;

  // First eligible queue searching circularly from the round pointer.
  always_comb begin
    int idx;
    w_sel   = '0;
    w_found = 1'b0;
    idx     = 0;
    for (int i = 0; i < NUM_QUEUES; i++) begin
      idx = int'(r_ptr) + i;
      if (idx >= NUM_QUEUES) idx = idx - NUM_QUEUES;
      if (!w_found && w_elig[idx]) begin
        w_found = 1'b1;
        w_sel   = idx[QW-1:0];
      end
    end
  end

  assign w_head      = w_dout[r_cur];
  assign w_head_ctrl = w_head[EW-1:DATA_WIDTH];
  assign w_do_pop    = (r_state == ST_XFER) && bus.out_rdy && !w_empty[r_cur];
  // End of packet is the first nonzero ctrl after a payload (ctrl==0) word.
  assign w_last      = r_prev_zero && (w_head_ctrl != '0);
  assign w_ptr_nxt   = (r_cur == QW'(NUM_QUEUES-1)) ? '0 : r_cur + QW'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_SELECT;
      r_ptr       <= '0;
      r_cur       <= '0;
      r_credit    <= '0;
      r_prev_zero <= 1'b0;
      r_out_data  <= '0;
      r_out_ctrl  <= '0;
      r_out_wr    <= 1'b0;
      r_eop       <= 1'b0;
      r_rs        <= 1'b0;
    end else begin
      r_out_wr <= 1'b0;
      r_eop    <= 1'b0;
      r_rs     <= 1'b0;
      case (r_state)
        ST_SELECT: begin
          if (w_found) begin
            r_cur       <= w_sel;
            r_prev_zero <= 1'b0;
            r_state     <= ST_XFER;
          end else if (|w_backlog) begin
            for (int q = 0; q < NUM_QUEUES; q++) r_credit[q] <= w_wt[q];
            r_rs <= 1'b1;
          end
        end
        ST_XFER: begin
          if (w_do_pop) begin
            r_out_wr    <= 1'b1;
            r_out_data  <= w_head[DATA_WIDTH-1:0];
            r_out_ctrl  <= w_head_ctrl;
            r_prev_zero <= (w_head_ctrl == '0);
            if (w_last) begin
              r_eop <= 1'b1;
              if (r_credit[r_cur] != '0)
                r_credit[r_cur] <= r_credit[r_cur] - WEIGHT_WIDTH'(1);
              // Stay on this queue only if it still has credit and data queued.
              if (!((r_credit[r_cur] > WEIGHT_WIDTH'(1)) && w_more[r_cur]))
                r_ptr <= w_ptr_nxt;
              r_state <= ST_SELECT;
            end
          end
        end
        default: r_state <= ST_SELECT;
      endcase
    end
  end

  assign bus.out_data    = r_out_data;
  assign bus.out_ctrl    = r_out_ctrl;
  assign bus.out_wr      = r_out_wr;
  assign bus.cur_queue   = r_cur;
  assign bus.eop         = r_eop;
  assign bus.round_start = r_rs;
endmodule

// File: tb/tb_wrr_pkt_arbiter.sv
// Directed bench for wrr_pkt_arbiter: per-queue word scoreboards plus an
// expected grant-order queue, checked as output words appear.
module tb_wrr_pkt_arbiter;
  localparam int NQ = 4, DW = 64, CW = 8, WW = 4, FDB = 2;

  logic clk, reset;
  wrr_pkt_arbiter_if #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .NUM_QUEUES(NQ), .WEIGHT_WIDTH(WW)) bus ();

  wrr_pkt_arbiter #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .NUM_QUEUES(NQ),
                    .WEIGHT_WIDTH(WW), .FIFO_DEPTH_BITS(FDB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  logic [DW+CW-1:0] sb [NQ][$];
  int gexp [$];
  int feed_left [NQ], wptr [NQ], pktn [NQ], wr_q [NQ];
  bit in_pkt, toggle_rdy, seen_wr, rs_before_wr;
  int cur_exp, wr_cnt, rs_cnt;
  logic [7:0] ctrl_tbl [4] = '{8'hFF, 8'h00, 8'h00, 8'h80};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_bench();
    for (int q = 0; q < NQ; q++) begin
      sb[q].delete();
      feed_left[q] = 0; wptr[q] = 0; pktn[q] = 0; wr_q[q] = 0;
    end
    gexp.delete();
    in_pkt = 0; toggle_rdy = 0; seen_wr = 0; rs_before_wr = 0;
    cur_exp = 0; wr_cnt = 0; rs_cnt = 0;
    bus.in_wr = '0; bus.in_data = '0; bus.in_ctrl = '0; bus.out_rdy = 1'b1;
  endtask

  task automatic monitor();
    logic [DW+CW-1:0] e;
    if (bus.out_wr === 1'b1) begin
      wr_cnt++;
      seen_wr = 1;
      chk("wr_after_rdy", bus.out_rdy, 1);
      if (!in_pkt) begin
        chk("grant_expected", gexp.size() != 0, 1);
        if (gexp.size() != 0) begin
          cur_exp = gexp.pop_front();
          chk("grant_queue", bus.cur_queue, cur_exp);
          in_pkt = 1;
        end
      end
      if (in_pkt) begin
        chk("word_expected", sb[cur_exp].size() != 0, 1);
        if (sb[cur_exp].size() != 0) begin
          e = sb[cur_exp].pop_front();
          chk("out_data", bus.out_data, e[DW-1:0]);
          chk("out_ctrl", bus.out_ctrl, e[DW+CW-1:DW]);
          chk("eop", bus.eop, e[DW+CW-1:DW] == 8'h80);
          if (e[DW+CW-1:DW] == 8'h80) in_pkt = 0;
        end
      end
    end else begin
      chk("eop_idle", bus.eop, 0);
    end
    if (bus.round_start === 1'b1) begin
      rs_cnt++;
      if (!seen_wr) rs_before_wr = 1;
    end
  endtask

  task automatic feed();
    logic [DW-1:0] d;
    for (int q = 0; q < NQ; q++) begin
      if (feed_left[q] > 0 && bus.in_rdy[q]) begin
        d = {8'(q), 24'(pktn[q]), 8'(wptr[q]), 24'h5A5A5A};
        bus.in_wr[q] = 1'b1;
        bus.in_data[q*DW +: DW] = d;
        bus.in_ctrl[q*CW +: CW] = ctrl_tbl[wptr[q]];
        sb[q].push_back({ctrl_tbl[wptr[q]], d});
        wr_q[q]++;
        wptr[q]++;
        if (wptr[q] == 4) begin
          wptr[q] = 0; pktn[q]++; feed_left[q]--;
        end
      end else begin
        bus.in_wr[q] = 1'b0;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    feed();
    if (toggle_rdy) bus.out_rdy = ~bus.out_rdy;
  endtask

  task automatic wait_done(input string tag, input int limit);
    int n = 0;
    while (!(gexp.size() == 0 && !in_pkt) && n < limit) begin
      step(); n++;
    end
    chk({tag, "_done"}, n < limit, 1);
    repeat (6) step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_bench();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int n;
    reset = 1'b0;
    bus.weights = '0;
    clear_bench();
    #1 reset = 1'b1;
    @(negedge clk);
    chk("rst_out_wr", bus.out_wr, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_ctrl", bus.out_ctrl, 0);
    chk("rst_eop", bus.eop, 0);
    chk("rst_round_start", bus.round_start, 0);
    chk("rst_cur_queue", bus.cur_queue, 0);
    chk("rst_in_rdy", bus.in_rdy, 4'hF);

    // weights {1,2,3,1}, all backlogged for two rounds
    do_reset();
    bus.weights = 16'h1321;
    feed_left = '{2, 4, 6, 2};
    repeat (2) foreach (ctrl_tbl[i]) begin end
    for (int r = 0; r < 2; r++) begin
      gexp.push_back(0); gexp.push_back(1); gexp.push_back(1);
      gexp.push_back(2); gexp.push_back(2); gexp.push_back(2); gexp.push_back(3);
    end
    wait_done("wrr", 2000);
    chk("wrr_round_starts", rs_cnt, 2);
    chk("wrr_out_wr", wr_cnt, 56);

    // only q2 backlogged, weights all 2
    do_reset();
    bus.weights = 16'h2222;
    feed_left = '{0, 0, 4, 0};
    repeat (4) gexp.push_back(2);
    wait_done("solo", 1000);
    chk("solo_round_starts", rs_cnt, 2);
    chk("solo_out_wr", wr_cnt, 16);

    // weight 0 on q1 with q1 backlogged
    do_reset();
    bus.weights = 16'h1101;
    feed_left = '{1, 1, 0, 1};
    gexp.push_back(0); gexp.push_back(3);
    wait_done("zero_w", 1000);
    chk("zero_w_in_rdy1", bus.in_rdy[1], 0);
    chk("zero_w_writes_q1", wr_q[1], 3);
    chk("zero_w_q1_held", sb[1].size(), 3);
    chk("zero_w_out_wr", wr_cnt, 8);

    // out_rdy toggling during a q0 packet
    do_reset();
    bus.weights = 16'h1111;
    feed_left = '{1, 0, 0, 0};
    gexp.push_back(0);
    toggle_rdy = 1;
    wait_done("stall", 1000);
    toggle_rdy = 0;
    bus.out_rdy = 1'b1;
    chk("stall_out_wr", wr_cnt, 4);

    // async reset in the middle of a q3 packet
    do_reset();
    bus.weights = 16'h1111;
    feed_left = '{0, 0, 0, 1};
    gexp.push_back(3);
    n = 0;
    while (wr_cnt < 2 && n < 200) begin
      step(); n++;
    end
    chk("midrst_reached", n < 200, 1);
    #2 reset = 1'b1;
    #1;
    chk("midrst_out_wr", bus.out_wr, 0);
    chk("midrst_eop", bus.eop, 0);
    chk("midrst_cur_queue", bus.cur_queue, 0);
    clear_bench();
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_in_rdy", bus.in_rdy, 4'hF);
    feed_left = '{1, 0, 0, 0};
    gexp.push_back(0);
    wait_done("postrst", 1000);
    chk("postrst_reload_first", rs_before_wr, 1);
    chk("postrst_out_wr", wr_cnt, 4);

    // weight of q0 raised 1->3 mid-round
    do_reset();
    bus.weights = 16'h1111;
    feed_left = '{4, 2, 0, 0};
    gexp.push_back(0); gexp.push_back(1);
    gexp.push_back(0); gexp.push_back(0); gexp.push_back(0); gexp.push_back(1);
    n = 0;
    while (wr_cnt < 1 && n < 200) begin
      step(); n++;
    end
    chk("wchg_started", n < 200, 1);
    bus.weights[3:0] = 4'd3;
    wait_done("wchg", 2000);
    chk("wchg_round_starts", rs_cnt, 2);
    chk("wchg_out_wr", wr_cnt, 24);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
